// File: rtl/apb4_master.sv
// apb4_master: command/response to APB4 requester bridge.
// Each accepted command runs one APB4 transfer: IDLE -> SETUP -> ACCESS -> RESP.
// The response is held in RESP until it is consumed.
// Optional feature: define APB4_MASTER_TIMEOUT_EN to abort a transfer that has
// waited TIMEOUT_CYCLES ACCESS cycles without pready_i. An aborted transfer
// returns rsp_err_o = 1.
module apb4_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
  input  logic                      cmd_write_i,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb_i,
  input  logic [2:0]                cmd_prot_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic [ADDR_WIDTH-1:0]     paddr_o,
  output logic [2:0]                pprot_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [DATA_WIDTH-1:0]     pwdata_o,
  output logic [DATA_WIDTH/8-1:0]   pstrb_o,
  input  logic                      pready_i,
  input  logic [DATA_WIDTH-1:0]     prdata_i,
  input  logic                      pslverr_i
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0] state;
  logic       timeout_hit;

`ifdef APB4_MASTER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] timeout_cnt;

  // pready_i on the terminal cycle wins, so the timeout only fires while pready_i is low.
  assign timeout_hit = (state == ACCESS) && !pready_i &&
                       (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS wait cycles; cleared during SETUP so each transfer starts from zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      timeout_cnt <= '0;
    end else if (state == SETUP) begin
      timeout_cnt <= '0;
    end else if ((state == ACCESS) && !pready_i && !timeout_hit) begin
      timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;

  // Without the timeout feature ACCESS waits for pready_i indefinitely.
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Transfer sequencer; every APB and response output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      pprot_o     <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            state       <= SETUP;
            cmd_ready_o <= 1'b0;
            psel_o      <= 1'b1;
            penable_o   <= 1'b0;
            paddr_o     <= cmd_addr_i;
            pwrite_o    <= cmd_write_i;
            pprot_o     <= cmd_prot_i;
            pwdata_o    <= cmd_write_i ? cmd_wdata_i : '0;
            pstrb_o     <= cmd_write_i ? cmd_wstrb_i : '0;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            state       <= RESP;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= pslverr_i;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
          end else if (timeout_hit) begin
            state       <= RESP;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master.sv
// tb_apb4_master: directed and randomized checks of apb4_master against a
// transaction-level expectation. The expectation is computed from the wait count,
// the error flag and the command, and compared with the observed bus cycles.
// Define APB4_MASTER_TIMEOUT_EN to run the timeout scenarios.
module tb_apb4_master;

  localparam int TMO = 8;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int compared;
  int mismatched;

  apb4_master #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_addr_i  (cmd_addr),
    .cmd_write_i (cmd_write),
    .cmd_wdata_i (cmd_wdata),
    .cmd_wstrb_i (cmd_wstrb),
    .cmd_prot_i  (cmd_prot),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .paddr_o     (paddr),
    .pprot_o     (pprot),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .pwdata_o    (pwdata),
    .pstrb_o     (pstrb),
    .pready_i    (pready),
    .prdata_i    (prdata),
    .pslverr_i   (pslverr)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One complete transfer: issue the command, act as the completer, and consume the response.
  task automatic applyStimulus(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic [2:0] prot, input int waits,
                               input logic slverr, input logic [31:0] rdata, input int resp_hold,
                               input bit hold_valid);
    int          c;
    int          sel_n;
    int          en_n;
    int          lat;
    int          eff;
    bit          seen;
    bit          timed_out;
    logic [31:0] exp_rdata;
    logic        exp_err;

    timed_out = 1'b0;
`ifdef APB4_MASTER_TIMEOUT_EN
    timed_out = (waits >= TMO);
`endif
    eff       = timed_out ? TMO - 1 : waits;
    exp_rdata = (write || timed_out) ? 32'h0 : rdata;
    exp_err   = timed_out ? 1'b1 : slverr;

    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = write;
    cmd_wdata = wdata;
    cmd_wstrb = wstrb;
    cmd_prot  = prot;
    rsp_ready = 1'b0;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 1);
    tick();

    // Change the command bus so later checks prove the fields were latched.
    cmd_valid = hold_valid;
    cmd_addr  = $urandom;
    cmd_write = ~write;
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    cmd_prot  = 3'($urandom);

    sel_n = 0;
    en_n  = 0;
    lat   = 0;
    seen  = 1'b0;
    c     = 1;
    while (!seen && c <= eff + 8) begin
      checkOutput("cmd_ready_busy", 32'(cmd_ready), 0);
      if (psel) begin
        sel_n++;
        checkOutput("paddr", paddr, addr);
        checkOutput("pwrite", 32'(pwrite), 32'(write));
        checkOutput("pwdata", pwdata, write ? wdata : 32'h0);
        checkOutput("pstrb", 32'(pstrb), write ? 32'(wstrb) : 32'h0);
        checkOutput("pprot", 32'(pprot), 32'(prot));
      end
      if (penable) en_n++;
      if (rsp_valid) begin
        seen = 1'b1;
        lat  = c;
      end else begin
        if (penable && en_n == waits + 1) begin
          pready  = 1'b1;
          prdata  = rdata;
          pslverr = slverr;
        end else if (penable) begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom);
        end else begin
          pready  = 1'b1;
          prdata  = $urandom;
          pslverr = 1'b1;
        end
        tick();
        c++;
      end
    end

    checkOutput("rsp_seen", 32'(seen), 1);
    checkOutput("psel_cycles", sel_n, 2 + eff);
    checkOutput("penable_cycles", en_n, 1 + eff);
    checkOutput("rsp_latency", lat, 3 + eff);
    checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
    checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    checkOutput("resp_psel", 32'(psel), 0);
    checkOutput("resp_penable", 32'(penable), 0);

    for (int h = 0; h < resp_hold; h++) begin
      pready = 1'($urandom);
      prdata = $urandom;
      tick();
      checkOutput("rsp_hold_valid", 32'(rsp_valid), 1);
      checkOutput("rsp_hold_rdata", rsp_rdata, exp_rdata);
      checkOutput("rsp_hold_err", 32'(rsp_err), 32'(exp_err));
    end

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    checkOutput("rsp_done_valid", 32'(rsp_valid), 0);
    checkOutput("idle_ready", 32'(cmd_ready), 1);
    checkOutput("idle_psel", 32'(psel), 0);
  endtask

  // Linear sequence of directed and randomized scenarios.
  initial begin
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [31:0] r_rdata;
    logic        r_write;
    logic        r_err;
    logic [3:0]  r_strb;
    logic [2:0]  r_prot;
    int          r_wait;
    int          r_hold;
    int          setups;
    int          resps;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_addr   = '0;
    cmd_write  = 1'b0;
    cmd_wdata  = '0;
    cmd_wstrb  = '0;
    cmd_prot   = '0;
    rsp_ready  = 1'b0;
    pready     = 1'b0;
    prdata     = '0;
    pslverr    = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_psel", 32'(psel), 0);
    checkOutput("rst_penable", 32'(penable), 0);
    checkOutput("rst_pwrite", 32'(pwrite), 0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 0);
    checkOutput("rst_paddr", paddr, 0);
    checkOutput("rst_pwdata", pwdata, 0);
    checkOutput("rst_pstrb", 32'(pstrb), 0);
    checkOutput("rst_pprot", 32'(pprot), 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 1);
    #9 rst_n = 1'b1;
    tick();

    $display("[TB] directed write, zero wait");
    applyStimulus(32'h1000_0004, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'($urandom), 0, 1'b0, $urandom, 0, 1'b0);

    $display("[TB] directed read, five wait cycles");
    applyStimulus(32'h0000_0010, 1'b0, $urandom, 4'($urandom), 3'($urandom), 5, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);

    $display("[TB] read with slave error, response held");
    applyStimulus($urandom, 1'b0, $urandom, 4'($urandom), 3'($urandom), 2, 1'b1, $urandom, 3, 1'b0);

    $display("[TB] command valid held through a transfer");
    applyStimulus($urandom, 1'b1, $urandom, 4'($urandom), 3'($urandom), 1, 1'b0, $urandom, 1, 1'b1);

    $display("[TB] back-to-back commands");
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = $urandom;
    rsp_ready = 1'b1;
    pready    = 1'b1;
    pslverr   = 1'b0;
    prdata    = $urandom;
    setups    = 0;
    resps     = 0;
    checkOutput("b2b_ready_start", 32'(cmd_ready), 1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (psel && !penable) setups++;
      if (rsp_valid) resps++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checkOutput("b2b_setups", setups, 3);
    checkOutput("b2b_responses", resps, 3);
    checkOutput("b2b_ready_end", 32'(cmd_ready), 1);

    $display("[TB] randomized transfers");
    for (int i = 0; i < 8; i++) begin
      r_addr  = $urandom;
      r_data  = $urandom;
      r_rdata = $urandom;
      r_write = 1'($urandom_range(0, 1));
      r_err   = 1'($urandom_range(0, 1));
      r_strb  = 4'($urandom);
      r_prot  = 3'($urandom);
      r_wait  = int'($urandom_range(0, 6));
      r_hold  = int'($urandom_range(0, 2));
      applyStimulus(r_addr, r_write, r_data, r_strb, r_prot, r_wait, r_err, r_rdata, r_hold, 1'b0);
    end

    $display("[TB] reset during ACCESS");
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = $urandom | 32'h1;
    cmd_wdata = $urandom | 32'h1;
    cmd_wstrb = 4'hF;
    pready    = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    checkOutput("pre_rst_penable", 32'(penable), 1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_psel", 32'(psel), 0);
    checkOutput("async_rst_penable", 32'(penable), 0);
    checkOutput("async_rst_paddr", paddr, 0);
    checkOutput("async_rst_pwdata", pwdata, 0);
    checkOutput("async_rst_cmd_ready", 32'(cmd_ready), 1);
    #2 rst_n = 1'b1;
    tick();
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 1);
    checkOutput("post_rst_psel", 32'(psel), 0);
    applyStimulus($urandom, 1'b0, $urandom, 4'($urandom), 3'($urandom), 3, 1'b0, $urandom, 0, 1'b0);

`ifdef APB4_MASTER_TIMEOUT_EN
    $display("[TB] pready on the terminal timeout cycle");
    applyStimulus($urandom, 1'b0, $urandom, 4'($urandom), 3'($urandom), TMO - 1, 1'b0, $urandom, 0, 1'b0);
    $display("[TB] pready stuck low, timeout");
    applyStimulus($urandom, 1'b0, $urandom, 4'($urandom), 3'($urandom), 1000, 1'b0, $urandom, 1, 1'b0);
`else
    $display("[TB] long wait without timeout");
    applyStimulus($urandom, 1'b0, $urandom, 4'($urandom), 3'($urandom), 20, 1'b0, $urandom, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
